seq_detector_param: RTL

Parametrised serial pattern detector. It is the successor to the fixed 3-bit "100" detector FSM.
- Pattern (up to MAX_LEN bits) and its length are programmable at run time.
- Input bits are qualified by a valid strobe.
- Overlapping or non-overlapping match mode is selectable.
- A saturating match counter is kept.
It sits on a serial bit stream in the datapath and produces a one-cycle match pulse plus status for control logic.

---
 rtl/seq_det_pkg.sv | 7 +
 rtl/seq_detector_param_if.sv | 22 ++
 rtl/seq_match_counter.sv | 17 +
 rtl/seq_detector_param.sv | 76 +++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type and length-to-mask helper for serial pattern detectors.
package seq_det_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [63:0] len_mask(input int unsigned len);
    return (len >= 64) ? '1 : (64'(1) << len) - 64'(1);
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: configuration, serial-stream and status bundle of the pattern detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16
);
  logic               en;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               a;
  logic               a_valid;
  logic               clr_count;
  logic               y;
  logic               busy;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;
  modport master (output en, pattern, pat_len, overlap, a, a_valid, clr_count,
                  input y, busy, cfg_err, match_count);
  modport slave (input en, pattern, pat_len, overlap, a, a_valid, clr_count,
                 output y, busy, cfg_err, match_count);
endinterface

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating event counter; a clear coinciding with an increment yields 1.
module seq_match_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (i_clr) r_count <= W'(i_inc);
    else if (i_inc && r_count != '1) r_count <= r_count + W'(1);
  assign o_count = r_count;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with
// overlap control, registered one-cycle match pulse and saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  seq_detector_param_if.slave bus
);
  state_t             r_state;
  logic [MAX_LEN-2:0] r_hist;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len, r_fill;
  logic               r_ovl, r_y, r_busy, r_cfg_err;
  logic [MAX_LEN-1:0] w_cand, w_mask;
  logic [LEN_W-1:0]   w_len_in, w_fill_inc;
  logic [LEN_W:0]     w_fill1;
  logic               w_match;
  assign w_len_in   = (bus.pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.pat_len;
  assign w_cand     = {r_hist, bus.a};
  assign w_mask     = MAX_LEN'(len_mask(32'(r_len)));
  assign w_fill1    = {1'b0, r_fill} + (LEN_W + 1)'(1);
  assign w_fill_inc = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : w_fill1[LEN_W-1:0];
  // len==0 gives an all-zero mask, so it must be excluded explicitly
  assign w_match = (r_state == RUN) && bus.en && bus.a_valid && (r_len != '0) &&
                   (w_fill1 >= {1'b0, r_len}) && (((w_cand ^ r_pat) & w_mask) == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_y       <= 1'b0;
      r_busy    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_y <= w_match;
      if (r_state == IDLE) begin
        r_hist <= '0;
        r_fill <= '0;
        if (bus.en) begin
          r_state   <= RUN;
          r_pat     <= bus.pattern;
          r_len     <= w_len_in;
          r_ovl     <= bus.overlap;
          r_busy    <= 1'b1;
          r_cfg_err <= (w_len_in == '0);
        end
      end else if (!bus.en) begin
        r_state   <= IDLE;
        r_hist    <= '0;
        r_fill    <= '0;
        r_busy    <= 1'b0;
        r_cfg_err <= 1'b0;
      end else if (bus.a_valid) begin
        r_hist <= (w_match && !r_ovl) ? '0 : w_cand[MAX_LEN-2:0];
        r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
      end
    end
  seq_match_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.clr_count),
    .i_inc   (w_match),
    .o_count (bus.match_count)
  );
  assign bus.y       = r_y;
  assign bus.busy    = r_busy;
  assign bus.cfg_err = r_cfg_err;
endmodule
